// File: rtl/strided_buffer_reader_pkg.sv
// Shared definitions for the strided feature-map buffer: shape bus layout, default geometry
// and the reader FSM encoding.
package strided_buffer_reader_pkg;

    localparam int unsigned N_BUF_X_DEFAULT    = 5;
    localparam int unsigned B_BUF_ADDR_DEFAULT = 9;
    localparam int unsigned DATA_WIDTH_DEFAULT = 64;
    localparam int unsigned B_SHAPE_DEFAULT    = 25;

    localparam int unsigned W_LSB    = 0;
    localparam int unsigned H_LSB    = 9;
    localparam int unsigned C_LSB    = 18;
    localparam int unsigned W_BITS   = 9;
    localparam int unsigned H_BITS   = 9;
    localparam int unsigned C_BITS   = 7;
    localparam int unsigned COL_BITS = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } rd_state_e;

    // Words occupied by one column in a bank.
    function automatic logic [COL_BITS-1:0] col_words(input logic [H_BITS-1:0] h,
                                                      input logic [C_BITS-1:0] nc);
        return COL_BITS'(h) * COL_BITS'(nc);
    endfunction

endpackage

// File: rtl/strided_rd_skid.sv
// Two-entry fall-through FIFO between the bank reads and the consumer; an empty FIFO
// presents the pushed word in the same cycle.
module strided_rd_skid #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [1:0]       count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       count_q;
    logic             empty, store, deq;

    always_comb begin
        empty     = (count_q == 2'd0);
        out_valid = !empty || push;
        out_data  = empty ? push_data : mem_q[rd_ptr_q];
        // Bypassed words never occupy an entry.
        store     = push && !(empty && out_ready);
        deq       = !empty && out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (store) wr_ptr_q <= !wr_ptr_q;
            if (deq)   rd_ptr_q <= !rd_ptr_q;
            count_q <= count_q + {1'b0, store} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;

endmodule

// File: rtl/strided_buffer_reader.sv
// Read side of the strided feature-map buffer: walks a stride-1 window of N_BUF_X columns
// across the banks, rotates bank outputs into column order and streams them out.
module strided_buffer_reader
    import strided_buffer_reader_pkg::*;
#(
    parameter int unsigned N_BUF_X    = N_BUF_X_DEFAULT,
    parameter int unsigned B_BUF_ADDR = B_BUF_ADDR_DEFAULT,
    parameter int unsigned B_SHAPE    = B_SHAPE_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clr,
    input  logic                           start,
    input  logic [B_SHAPE-1:0]             shape,
    output logic [B_BUF_ADDR*N_BUF_X-1:0]  rdaddr,
    input  logic [DATA_WIDTH*N_BUF_X-1:0]  bram_do,
    output logic [DATA_WIDTH*N_BUF_X-1:0]  out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned RB     = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;
    localparam int unsigned DW_ALL = DATA_WIDTH * N_BUF_X;

    rd_state_e                      state_q;
    logic [W_BITS-1:0]              w_q, xo_q;
    logic [H_BITS-1:0]              h_q, y_q;
    logic [C_BITS-1:0]              nc_q, c_q;
    logic [COL_BITS-1:0]            col_size_q, off_q;
    logic [B_BUF_ADDR-1:0]          base_q [N_BUF_X];
    logic [RB-1:0]                  rot_q, tag_rot_q;
    logic                           inflight_q, tag_last_q, done_q;
    logic [B_BUF_ADDR*N_BUF_X-1:0]  rdaddr_q, rdaddr_d;
    logic [1:0]                     fifo_count;
    logic [2:0]                     occupancy;
    logic                           issue, c_wrap, y_wrap, last_issue;
    logic [DW_ALL-1:0]              rot_data;
    logic [DW_ALL:0]                fifo_out;

    always_comb begin
        occupancy  = {1'b0, fifo_count} + {2'b0, inflight_q};
        issue      = (state_q == StRun) && (occupancy < 3'd2);
        c_wrap     = (c_q == nc_q - C_BITS'(1));
        y_wrap     = (y_q == h_q - H_BITS'(1));
        last_issue = (xo_q == w_q - W_BITS'(N_BUF_X)) && y_wrap && c_wrap;
        rdaddr_d   = rdaddr_q;
        if (issue) begin
            for (int b = 0; b < N_BUF_X; b++) begin
                rdaddr_d[b*B_BUF_ADDR +: B_BUF_ADDR] = base_q[b] + off_q[B_BUF_ADDR-1:0];
            end
        end
    end

    // Lane k takes the bank holding column xo+k.
    always_comb begin
        rot_data = '0;
        for (int k = 0; k < N_BUF_X; k++) begin
            for (int r = 0; r < N_BUF_X; r++) begin
                if (tag_rot_q == RB'(r)) begin
                    rot_data[k*DATA_WIDTH +: DATA_WIDTH] =
                        bram_do[((r + k) % N_BUF_X)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            state_q    <= StIdle;
            w_q        <= '0;
            h_q        <= '0;
            nc_q       <= '0;
            col_size_q <= '0;
            xo_q       <= '0;
            y_q        <= '0;
            c_q        <= '0;
            off_q      <= '0;
            rot_q      <= '0;
            tag_rot_q  <= '0;
            tag_last_q <= 1'b0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            rdaddr_q   <= '0;
            for (int b = 0; b < N_BUF_X; b++) base_q[b] <= '0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            tag_rot_q  <= rot_q;
            tag_last_q <= issue && last_issue;
            rdaddr_q   <= rdaddr_d;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        w_q     <= shape[W_LSB +: W_BITS];
                        h_q     <= shape[H_LSB +: H_BITS];
                        nc_q    <= shape[C_LSB +: C_BITS];
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    col_size_q <= col_words(h_q, nc_q);
                    xo_q       <= '0;
                    y_q        <= '0;
                    c_q        <= '0;
                    off_q      <= '0;
                    rot_q      <= '0;
                    for (int b = 0; b < N_BUF_X; b++) base_q[b] <= '0;
                    if (w_q < W_BITS'(N_BUF_X) || h_q == '0 || nc_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (issue) begin
                        if (!c_wrap) begin
                            c_q   <= c_q + C_BITS'(1);
                            off_q <= off_q + COL_BITS'(1);
                        end else if (!y_wrap) begin
                            c_q   <= '0;
                            y_q   <= y_q + H_BITS'(1);
                            off_q <= off_q + COL_BITS'(1);
                        end else begin
                            // Window slides: the bank of column xo now serves column xo+N_BUF_X.
                            c_q   <= '0;
                            y_q   <= '0;
                            off_q <= '0;
                            xo_q  <= xo_q + W_BITS'(1);
                            rot_q <= (rot_q == RB'(N_BUF_X - 1)) ? '0 : rot_q + RB'(1);
                            for (int b = 0; b < N_BUF_X; b++) begin
                                if (rot_q == RB'(b)) begin
                                    base_q[b] <= base_q[b] + col_size_q[B_BUF_ADDR-1:0];
                                end
                            end
                        end
                        if (last_issue) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (out_valid && out_ready && out_last) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    strided_rd_skid #(
        .WIDTH(DW_ALL + 1)
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .push     (inflight_q),
        .push_data({tag_last_q, rot_data}),
        .count    (fifo_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (fifo_out)
    );

    assign out_data = fifo_out[DW_ALL-1:0];
    assign out_last = fifo_out[DW_ALL];
    assign rdaddr   = rdaddr_d;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

endmodule

// File: tb/tb_strided_buffer_reader.sv
// Randomized bench for strided_buffer_reader: bank memory model plus a beat-list reference
// built directly from the column/row/channel walk.
module tb_strided_buffer_reader;

    localparam int N  = 5;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int SW = 25;
    localparam int CW = DW * N;

    typedef struct {
        logic [CW-1:0] data;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rstn, clr, start, out_ready;
    logic [SW-1:0]   shape;
    logic [AW*N-1:0] rdaddr;
    logic [CW-1:0]   bram_do, out_data;
    logic            out_valid, out_last, busy, done;

    logic [DW-1:0]   mem [N][512];
    beat_t           exp_q [$];
    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              beats, done_cnt, first_valid_cyc, done_cyc, probe_cyc;
    logic [AW*N-1:0] probe_addr;
    bit              mon_en, hold_prev;

    strided_buffer_reader dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .start    (start),
        .shape    (shape),
        .rdaddr   (rdaddr),
        .bram_do  (bram_do),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = !clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Banks with one cycle of read latency.
    always @(posedge clk) begin
        for (int b = 0; b < N; b++) bram_do[b*DW +: DW] <= mem[b][rdaddr[b*AW +: AW]];
    end

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int x, input int y, input int c);
        return {16'(x), 16'(y), 16'(c), 16'hBEEF};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_prev) check("hold_valid", CW'(out_valid), CW'(1));
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("spare_beat", CW'(out_valid), CW'(0));
                end else begin
                    check("beat_data", out_data, exp_q[0].data);
                    check("beat_last", CW'(out_last), CW'(exp_q[0].last));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == probe_cyc) check("rdaddr_probe", CW'(rdaddr), CW'(probe_addr));
        end
    end

    // mode 0: ready always, 1: 1010 with a 5-cycle stall before beat 6, 2: random ready.
    task automatic run_frame(input int w, input int h, input int nc, input int mode,
                             input int clr_beat, input bit poke, input bit timing);
        int    t0, stall_left, n_beats;
        bit    stalled, aborted, poked, toggle;
        beat_t bt;
        stall_left = 0;
        stalled    = 0;
        aborted    = 0;
        poked      = 0;
        toggle     = 1;
        for (int x = 0; x < w; x++)
            for (int y = 0; y < h; y++)
                for (int c = 0; c < nc; c++)
                    mem[x % N][((x / N) * h * nc + y * nc + c) % 512] = word(x, y, c);
        exp_q.delete();
        if (w >= N) begin
            for (int xo = 0; xo <= w - N; xo++)
                for (int y = 0; y < h; y++)
                    for (int c = 0; c < nc; c++) begin
                        for (int k = 0; k < N; k++) bt.data[k*DW +: DW] = word(xo + k, y, c);
                        bt.last = (xo == w - N) && (y == h - 1) && (c == nc - 1);
                        exp_q.push_back(bt);
                    end
        end
        n_beats         = exp_q.size();
        beats           = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        done_cyc        = -1;
        hold_prev       = 0;
        out_ready       = 1'b1;

        @(posedge clk); #1;
        start = 1'b1;
        shape = {7'(nc), 9'(h), 9'(w)};
        t0    = cyc;
        probe_cyc = -1;
        if (timing) begin
            // Sixth issue: xo=1, off=1; bank 0 has advanced by one column.
            for (int b = 0; b < N; b++) probe_addr[b*AW +: AW] = AW'((b == 0 ? h * nc : 0) + 1);
            probe_cyc = t0 + 7;
        end
        mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start", CW'(busy), CW'(1));

        for (int i = 0; i < 4000; i++) begin
            if (done_cnt != 0 || aborted) break;
            case (mode)
                1: begin
                    if (!stalled && beats == 5) begin
                        stalled    = 1;
                        stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = toggle;
                        toggle    = !toggle;
                    end
                end
                2:       out_ready = ($urandom % 4) != 0;
                default: out_ready = 1'b1;
            endcase
            if (poke && !poked && beats == 3) begin
                start = 1'b1;
                shape = {7'd1, 9'd1, 9'd5};
                poked = 1;
            end else begin
                start = 1'b0;
            end
            if (clr_beat > 0 && beats == clr_beat - 1) begin
                clr = 1'b1;
                @(posedge clk); #1;
                clr = 1'b0;
                check("clr_valid", CW'(out_valid), CW'(0));
                check("clr_busy", CW'(busy), CW'(0));
                aborted = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;

        if (aborted) begin
            repeat (5) @(posedge clk);
            #1;
            check("clr_no_done", CW'(done_cnt), CW'(0));
            exp_q.delete();
        end else begin
            check("done_seen", CW'(done_cnt), CW'(1));
            repeat (4) @(posedge clk);
            #1;
            check("done_once", CW'(done_cnt), CW'(1));
            check("beat_count", CW'(beats), CW'(n_beats));
            check("queue_empty", CW'(exp_q.size()), CW'(0));
            check("busy_idle", CW'(busy), CW'(0));
            if (timing) begin
                check("first_valid_lat", CW'(first_valid_cyc - t0), CW'(3));
                check("done_lat", CW'(done_cyc - t0), CW'(15));
            end
        end
        mon_en    = 1'b0;
        probe_cyc = -1;
        out_ready = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        clr       = 1'b0;
        start     = 1'b0;
        shape     = '0;
        out_ready = 1'b1;
        mon_en    = 1'b0;
        probe_cyc = -1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdaddr", CW'(rdaddr), CW'(0));
        check("rst_valid", CW'(out_valid), CW'(0));
        check("rst_last", CW'(out_last), CW'(0));
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_done", CW'(done), CW'(0));
        rstn = 1'b1;

        run_frame(7, 2, 2, 0, 0, 0, 1);
        run_frame(7, 2, 2, 1, 0, 0, 0);
        run_frame(3, 4, 4, 0, 0, 0, 0);
        run_frame(12, 3, 8, 0, 0, 0, 0);
        run_frame(7, 2, 2, 0, 5, 0, 0);
        run_frame(7, 2, 2, 0, 0, 0, 0);
        run_frame(7, 2, 2, 0, 0, 1, 0);
        run_frame(9, 0, 3, 0, 0, 0, 0);
        run_frame(8, 2, 0, 0, 0, 0, 0);
        for (int t = 0; t < 6; t++) begin
            run_frame(int'($urandom_range(5, 20)), int'($urandom_range(1, 4)),
                      int'($urandom_range(1, 8)), 2, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
